// File: rtl/ball_centroid_tracker.sv
// Per-frame ball centroid tracker: classifies camera pixels, accumulates coordinate sums,
// then divides sum/count with a restoring divider and publishes ball_x/ball_y with a strobe.
module ball_centroid_tracker #(
    parameter logic [3:0]  R_MIN      = 4'd10,
    parameter logic [3:0]  GB_MAX     = 4'd5,
    parameter logic [5:0]  LUMA_MIN   = 6'd40,
    parameter logic [18:0] MIN_PIXELS = 19'd16,
    parameter logic [9:0]  X_LO       = 10'd20,
    parameter logic [9:0]  X_HI       = 10'd619,
    parameter logic [8:0]  Y_LO       = 9'd40,
    parameter logic [8:0]  Y_HI       = 9'd439
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic        sof,
    input  logic        eof,
    input  logic        pix_valid,
    input  logic [9:0]  pix_x,
    input  logic [8:0]  pix_y,
    input  logic [11:0] pix_data,
    input  logic        red_hue,
    output logic [9:0]  ball_x,
    output logic [8:0]  ball_y,
    output logic        ball_valid,
    output logic        change_ideal,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV_X,
        S_DIV_Y,
        S_UPDATE
    } state_t;

    localparam logic [4:0] LAST_STEP = 5'd27;

    logic [3:0]  w_r;
    logic [3:0]  w_g;
    logic [3:0]  w_b;
    logic [5:0]  w_luma;
    logic        w_in_roi;
    logic        w_hue_ok;
    logic        w_luma_ok;
    logic        w_ball_pix;
    logic [18:0] w_cnt_inc;
    logic [27:0] w_sum_x_inc;
    logic [27:0] w_sum_y_inc;

    logic [18:0] r_cnt;
    logic [27:0] r_sum_x;
    logic [27:0] r_sum_y;

    state_t      r_state;
    logic [4:0]  r_step;
    logic [18:0] r_den;
    logic [27:0] r_quo;
    logic [18:0] r_rem;
    logic [27:0] r_sum_y_op;
    logic [9:0]  r_quo_x;
    logic [9:0]  r_ball_x;
    logic [8:0]  r_ball_y;
    logic        r_ball_valid;
    logic        r_change;
    logic        r_overrun;

    logic [19:0] w_rem_shift;
    logic        w_rem_ge;
    logic [18:0] w_rem_next;
    logic [27:0] w_quo_next;

    assign w_r = pix_data[11:8];
    assign w_g = pix_data[7:4];
    assign w_b = pix_data[3:0];
    assign w_luma = {2'b00, w_r} + {2'b00, w_g} + {2'b00, w_b};

    assign w_in_roi  = (pix_x >= X_LO) && (pix_x <= X_HI) && (pix_y >= Y_LO) && (pix_y <= Y_HI);
    assign w_hue_ok  = (w_r >= R_MIN) && (w_g <= GB_MAX) && (w_b <= GB_MAX);
    assign w_luma_ok = (w_luma >= LUMA_MIN);
    assign w_ball_pix = pix_valid && w_in_roi && (red_hue ? w_hue_ok : w_luma_ok);

    // Running totals including this cycle's pixel; used both for accumulation and the eof snapshot.
    assign w_cnt_inc   = r_cnt + {18'd0, w_ball_pix};
    assign w_sum_x_inc = r_sum_x + {18'd0, pix_x & {10{w_ball_pix}}};
    assign w_sum_y_inc = r_sum_y + {19'd0, pix_y & {9{w_ball_pix}}};

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_sum_x <= '0;
            r_sum_y <= '0;
        end else if (eof) begin
            r_cnt   <= '0;
            r_sum_x <= '0;
            r_sum_y <= '0;
        end else if (sof) begin
            r_cnt   <= {18'd0, w_ball_pix};
            r_sum_x <= {18'd0, pix_x & {10{w_ball_pix}}};
            r_sum_y <= {19'd0, pix_y & {9{w_ball_pix}}};
        end else begin
            r_cnt   <= w_cnt_inc;
            r_sum_x <= w_sum_x_inc;
            r_sum_y <= w_sum_y_inc;
        end
    end

    // One restoring-division step: dividend bits shift out of r_quo's MSB, quotient bits in at LSB.
    assign w_rem_shift = {r_rem, r_quo[27]};
    assign w_rem_ge    = (w_rem_shift >= {1'b0, r_den});
    assign w_rem_next  = w_rem_ge ? 19'(w_rem_shift - {1'b0, r_den}) : w_rem_shift[18:0];
    assign w_quo_next  = {r_quo[26:0], w_rem_ge};

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_step       <= '0;
            r_den        <= '0;
            r_quo        <= '0;
            r_rem        <= '0;
            r_sum_y_op   <= '0;
            r_quo_x      <= '0;
            r_ball_x     <= '0;
            r_ball_y     <= '0;
            r_ball_valid <= 1'b0;
            r_change     <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_change <= 1'b0;
            if (eof && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (eof) begin
                        if (w_cnt_inc < MIN_PIXELS) begin
                            r_ball_valid <= 1'b0;
                        end else begin
                            r_den      <= w_cnt_inc;
                            r_quo      <= w_sum_x_inc;
                            r_sum_y_op <= w_sum_y_inc;
                            r_rem      <= '0;
                            r_step     <= '0;
                            r_state    <= S_DIV_X;
                        end
                    end
                end
                S_DIV_X: begin
                    if (r_step == LAST_STEP) begin
                        r_quo_x <= w_quo_next[9:0];
                        r_quo   <= r_sum_y_op;
                        r_rem   <= '0;
                        r_step  <= '0;
                        r_state <= S_DIV_Y;
                    end else begin
                        r_quo  <= w_quo_next;
                        r_rem  <= w_rem_next;
                        r_step <= r_step + 5'd1;
                    end
                end
                S_DIV_Y: begin
                    r_quo <= w_quo_next;
                    r_rem <= w_rem_next;
                    if (r_step == LAST_STEP) begin
                        r_step  <= '0;
                        r_state <= S_UPDATE;
                    end else begin
                        r_step <= r_step + 5'd1;
                    end
                end
                S_UPDATE: begin
                    r_ball_x     <= r_quo_x;
                    r_ball_y     <= r_quo[8:0];
                    r_ball_valid <= 1'b1;
                    r_change     <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ball_x       = r_ball_x;
    assign ball_y       = r_ball_y;
    assign ball_valid   = r_ball_valid;
    assign change_ideal = r_change;
    assign busy         = (r_state != S_IDLE);
    assign overrun      = r_overrun;

endmodule
